fp8_op_sequencer: RTL and testbench
===================================

// Module: fp8_op_sequencer
// PURPOSE
//  Byte-serial command sequencer in front of the tt_um_lightFP8 FP8 (E4M3) arithmetic unit.
//  Collects a command byte and up to two operand bytes over an 8-bit valid/ready stream, then drives the FPU with a start/done handshake.
//  Returns the result byte, and optionally a flags byte, on an output stream.
//  Holds an FP8 accumulator register so dot-product style chains need no operand reload.
// PARAMETERS
//  TIMEOUT   15     max cycles in WAIT for fpu_done before abort (1..255)
//  ACC_INIT  8'h00  accumulator value after reset / CLR command (+0.0)
// PORTS
//  clk         in   1  clock; all state on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  ena         in   1  design enable; low blocks new command acceptance
//  in_data     in   8  command/operand byte
//  in_valid    in   1  in_data valid
//  in_ready    out  1  sequencer accepts in_data this cycle
//  out_data    out  8  result or flags byte
//  out_valid   out  1  out_data valid
//  out_ready   in   1  consumer accepts out_data
//  fpu_start   out  1  one-cycle pulse: operands and op are valid
//  fpu_op      out  2  00 add, 01 sub, 10 mul, 11 reserved
//  fpu_a       out  8  operand A (E4M3)
//  fpu_b       out  8  operand B (E4M3)
//  fpu_done    in   1  FPU result valid (single-cycle pulse)
//  fpu_result  in   8  FPU result byte
//  fpu_flags   in   4  {NV,OF,UF,NX}
//  busy        out  1  state != IDLE
//  err         out  1  sticky: timeout or illegal command; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; every output 0; acc=ACC_INIT; err=0; timeout counter 0.
//  Handshake: a byte transfers when valid&&ready on a rising edge. out_data/out_valid hold until out_ready.
//  Command byte fields:
//   [1:0] op
//   [2]   A_ACC: A = acc, GET_A skipped
//   [3]   WR_ACC: write result into acc
//   [4]   FLAGS: emit flags byte after result
//   [5]   CLR: acc<=ACC_INIT; no operation performed, no output
//   [7:6] must be 0
//  Illegal command (op==11 or [7:6]!=0): err<=1; return to IDLE; one out byte 8'h7F (NaN).
//  States:
//   IDLE   in_ready=ena; on cmd -> GET_A, GET_B (if A_ACC) or IDLE (if CLR).
//   GET_A  in_ready=1; latch A -> GET_B.
//   GET_B  in_ready=1; latch B -> ISSUE.
//   ISSUE  fpu_start=1 for exactly one cycle -> WAIT; counter cleared.
//   WAIT   fpu_done ignored in the ISSUE cycle, accepted from the next cycle on.
//          On done: capture result and flags; acc<=result if WR_ACC -> SEND_R.
//          If counter reaches TIMEOUT: result=8'h7F, flags=4'b1000, err<=1, acc unchanged -> SEND_R.
//   SEND_R out_valid=1, out_data=result; on accept -> SEND_F (if FLAGS) else IDLE.
//   SEND_F out_data={4'h0,flags}; on accept -> IDLE.
//  fpu_a/fpu_b/fpu_op held stable from ISSUE until leaving WAIT.
//  Minimum latency, last operand accepted -> out_valid: 2 cycles plus FPU latency.
//  ena low mid-command: the in-flight command completes; only IDLE acceptance is gated.
//  Reset mid-operation aborts immediately. No output byte is produced and acc returns to ACC_INIT.
//  A stray fpu_done outside WAIT is ignored. in_ready=0 in ISSUE/WAIT/SEND_*.
//  The next command byte can be accepted in the cycle IDLE is re-entered.
// STRUCTURE
//  Package fp8_seq_pkg holds:
//   state enum
//   op codes and command bit positions
//   FP8_NAN=8'h7F and FP8 constants
//  Sub-module fp8_seq_watchdog: loadable TIMEOUT down-counter with expiry flag.
//  All other logic stays in the top FSM.
// TESTING
//  Bench drives a behavioural FPU stub with programmable latency 1..20.
//  1. mul 1.5*2.0: cmd 0x02, A 0x3C, B 0x40, stub latency 3
//     -> one fpu_start pulse; out 0x44; busy low after accept.
//  2. acc chain: CLR 0x20; cmd 0x08 (add,WR_ACC) A 0x38 B 0x38
//     -> out 0x40, acc=0x40; then cmd 0x0E (mul,A_ACC,WR_ACC) B 0x40 -> fpu_a=0x40, out 0x48.
//  3. flags: cmd 0x12 with stub flags 4'b0001 -> out 0x44 then 0x01.
//  4. timeout: stub never raises done, TIMEOUT=15
//     -> out 0x7F after 15 WAIT cycles; err=1; acc unchanged; a stray late done is ignored.
//  5. illegal cmd 0xC0 -> out 0x7F, err=1, no fpu_start.
//  6. backpressure/reset: out_ready low 5 cycles -> out_data stable.
//     Assert rst_n=0 during WAIT -> all outputs 0 and acc=0x00 at once.

Source files
------------

// File: rtl/fp8_seq_pkg.sv
// Shared types and constants for the FP8 (E4M3) byte-serial op sequencer.
// Command byte layout: [1:0] op, [2] A_ACC, [3] WR_ACC, [4] FLAGS, [5] CLR, [7:6] must be zero.
package fp8_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_ISSUE,
      ST_WAIT,
      ST_SEND_R,
      ST_SEND_F
   } seq_state_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } fpu_op_t;

   localparam int unsigned CMD_A_ACC  = 2;
   localparam int unsigned CMD_WR_ACC = 3;
   localparam int unsigned CMD_FLAGS  = 4;
   localparam int unsigned CMD_CLR    = 5;

   localparam logic [7:0] FP8_NAN      = 8'h7F;
   localparam logic [7:0] FP8_POS_ZERO = 8'h00;
   localparam logic [3:0] FLAG_NV      = 4'b1000;

   function automatic logic cmd_illegal(input logic [7:0] cmd);
      return (cmd[1:0] == OP_RSVD) || (cmd[7:6] != 2'b00);
   endfunction

endpackage

// File: rtl/fp8_seq_watchdog.sv
// Loadable down-counter that bounds how long the sequencer waits for fpu_done.
// o_expired fires during the last permitted run cycle, i.e. after exactly TIMEOUT run cycles.
module fp8_seq_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_run,
   output logic o_expired
);

   localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign o_expired = i_run && (r_cnt == 8'd1);

endmodule

// File: rtl/fp8_op_sequencer.sv
// Byte-serial command sequencer in front of an FP8 E4M3 FPU: gathers cmd/operands,
// runs one start/done transaction, and streams back the result and optional flags byte.
module fp8_op_sequencer
   import fp8_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 15,
   parameter logic [7:0]  ACC_INIT = FP8_POS_ZERO
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       fpu_start,
   output logic [1:0] fpu_op,
   output logic [7:0] fpu_a,
   output logic [7:0] fpu_b,
   input  logic       fpu_done,
   input  logic [7:0] fpu_result,
   input  logic [3:0] fpu_flags,
   output logic       busy,
   output logic       err
);

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   logic [1:0] r_op;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_acc;
   logic [7:0] r_res;
   logic [3:0] r_flags;
   logic       r_wr_acc;
   logic       r_flags_en;
   logic       r_err;

   logic       w_in_fire;
   logic       w_expired;
   logic       w_cmd_illegal;

   assign w_in_fire     = in_valid && in_ready;
   assign w_cmd_illegal = cmd_illegal(in_data);

   fp8_seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (r_state == ST_ISSUE),
      .i_run     (r_state == ST_WAIT),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      fpu_start   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // rst_n gating keeps in_ready low while reset is held, even with ena high
            in_ready = ena && rst_n;
            if (w_in_fire) begin
               if (w_cmd_illegal) begin
                  w_state_nxt = ST_SEND_R;
               end else if (in_data[CMD_CLR]) begin
                  w_state_nxt = ST_IDLE;
               end else if (in_data[CMD_A_ACC]) begin
                  w_state_nxt = ST_GET_B;
               end else begin
                  w_state_nxt = ST_GET_A;
               end
            end
         end
         ST_GET_A: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_GET_B;
         end
         ST_GET_B: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            fpu_start   = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (fpu_done || w_expired) w_state_nxt = ST_SEND_R;
         end
         ST_SEND_R: begin
            out_valid = 1'b1;
            out_data  = r_res;
            if (out_ready) w_state_nxt = r_flags_en ? ST_SEND_F : ST_IDLE;
         end
         ST_SEND_F: begin
            out_valid = 1'b1;
            out_data  = {4'h0, r_flags};
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= ACC_INIT;
         r_res      <= '0;
         r_flags    <= '0;
         r_wr_acc   <= 1'b0;
         r_flags_en <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_in_fire) begin
                  if (w_cmd_illegal) begin
                     r_err      <= 1'b1;
                     r_res      <= FP8_NAN;
                     r_flags_en <= 1'b0;
                  end else if (in_data[CMD_CLR]) begin
                     r_acc <= ACC_INIT;
                  end else begin
                     r_op       <= in_data[1:0];
                     r_wr_acc   <= in_data[CMD_WR_ACC];
                     r_flags_en <= in_data[CMD_FLAGS];
                     if (in_data[CMD_A_ACC]) r_a <= r_acc;
                  end
               end
            end
            ST_GET_A: begin
               if (in_valid) r_a <= in_data;
            end
            ST_GET_B: begin
               if (in_valid) r_b <= in_data;
            end
            ST_WAIT: begin
               // A done arriving on the expiry cycle still wins over the timeout
               if (fpu_done) begin
                  r_res   <= fpu_result;
                  r_flags <= fpu_flags;
                  if (r_wr_acc) r_acc <= fpu_result;
               end else if (w_expired) begin
                  r_res   <= FP8_NAN;
                  r_flags <= FLAG_NV;
                  r_err   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fpu_op = r_op;
   assign fpu_a  = r_a;
   assign fpu_b  = r_b;
   assign busy   = (r_state != ST_IDLE);
   assign err    = r_err;

endmodule

// File: tb/tb_fp8_op_sequencer.sv
// Self-checking bench for fp8_op_sequencer: behavioural FPU stub with programmable latency,
// directed scenarios followed by randomized commands checked against a transaction-level model.
module tb_fp8_op_sequencer;

   localparam int unsigned TO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       fpu_start;
   logic [1:0] fpu_op;
   logic [7:0] fpu_a;
   logic [7:0] fpu_b;
   logic       fpu_done;
   logic       fpu_done_s = 1'b0;
   logic       fpu_done_m = 1'b0;
   logic [7:0] fpu_result = '0;
   logic [3:0] fpu_flags = '0;
   logic       busy;
   logic       err;

   assign fpu_done = fpu_done_s | fpu_done_m;

   fp8_op_sequencer #(
      .TIMEOUT  (TO),
      .ACC_INIT (8'h00)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fpu_start  (fpu_start),
      .fpu_op     (fpu_op),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_done   (fpu_done),
      .fpu_result (fpu_result),
      .fpu_flags  (fpu_flags),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int          starts = 0;
   bit          stub_en = 1'b1;
   bit          stub_busy = 1'b0;
   int          stub_lat = 1;
   logic [3:0]  stub_flags = '0;
   logic [7:0]  cap_a = '0;
   logic [7:0]  cap_b = '0;
   logic [1:0]  cap_op = '0;

   // reference model state
   logic [7:0]  m_acc = 8'h00;
   logic        m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behaviour of the FPU stub: known E4M3 products/sums for the directed cases, a hash otherwise.
   function automatic logic [7:0] stub_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op == 2'b10 && a == 8'h3C && b == 8'h40) return 8'h44;
      if (op == 2'b00 && a == 8'h38 && b == 8'h38) return 8'h40;
      if (op == 2'b10 && a == 8'h40 && b == 8'h40) return 8'h48;
      return (a ^ {b[3:0], b[7:4]}) + {6'd0, op};
   endfunction

   // FPU stub: answers stub_lat cycles after the start pulse, checks operand hold while waiting
   initial begin
      forever begin
         @(negedge clk);
         if (fpu_start === 1'b1) begin
            starts++;
            cap_a  = fpu_a;
            cap_b  = fpu_b;
            cap_op = fpu_op;
            if (stub_en) begin
               stub_busy = 1'b1;
               repeat (stub_lat) @(posedge clk);
               #1;
               if (stub_lat <= int'(TO)) begin
                  chk("hold_a", fpu_a, cap_a);
                  chk("hold_b", fpu_b, cap_b);
                  chk("hold_op", fpu_op, cap_op);
               end
               fpu_result = stub_fn(cap_op, cap_a, cap_b);
               fpu_flags  = stub_flags;
               fpu_done_s = 1'b1;
               @(posedge clk);
               #1 fpu_done_s = 1'b0;
               stub_busy = 1'b0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic recv_byte(input logic [7:0] exp, input string tag, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_stall"}, {out_valid, out_data}, {1'b1, exp});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // One full command through the model; lat==0 means the stub never answers.
   task automatic run_op(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input logic [3:0] fl, input bit ena_drop, input int hold);
      int         s0;
      int         n;
      bit         illegal;
      bit         tmo;
      logic [7:0] exp_a;
      logic [7:0] exp_res;
      logic [3:0] exp_fl;
      s0         = starts;
      illegal    = (cmd[1:0] == 2'b11) || (cmd[7:6] != 2'b00);
      stub_en    = (lat != 0);
      stub_lat   = (lat == 0) ? 1 : lat;
      stub_flags = fl;
      send_byte(cmd, "cmd");
      if (illegal) begin
         m_err = 1'b1;
         recv_byte(8'h7F, "illegal", hold);
         chk("illegal_no_start", starts, s0);
      end else if (cmd[5]) begin
         m_acc = 8'h00;
         repeat (3) begin
            @(negedge clk);
            chk("clr_quiet", {out_valid, busy, fpu_start}, 3'b000);
         end
      end else begin
         if (ena_drop) ena = 1'b0;
         exp_a = cmd[2] ? m_acc : a;
         if (!cmd[2]) send_byte(a, "opA");
         send_byte(b, "opB");
         @(negedge clk);
         chk("start_pulse", fpu_start, 1);
         tmo     = (lat == 0) || (lat > int'(TO));
         exp_res = tmo ? 8'h7F : stub_fn(cmd[1:0], exp_a, b);
         exp_fl  = tmo ? 4'b1000 : fl;
         n = 0;
         while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("latency", n, tmo ? TO + 1 : lat + 1);
         chk("start_count", starts - s0, 1);
         chk("fpu_a", cap_a, exp_a);
         chk("fpu_b", cap_b, b);
         chk("fpu_op", cap_op, cmd[1:0]);
         if (tmo) m_err = 1'b1;
         else if (cmd[3]) m_acc = exp_res;
         recv_byte(exp_res, "result", hold);
         if (cmd[4]) recv_byte({4'h0, exp_fl}, "flags", hold);
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("err", err, m_err);
      ena = 1'b1;
      n = 0;
      while (stub_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [7:0] c;
      int         lat;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {in_ready, out_valid, out_data, fpu_start, fpu_op, fpu_a, fpu_b, busy, err}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      // 1.5 * 2.0
      run_op(8'h02, 8'h3C, 8'h40, 3, 4'h0, 1'b0, 0);
      chk("t1_one_start", starts, 1);

      // accumulator chain
      run_op(8'h20, 8'h00, 8'h00, 1, 4'h0, 1'b0, 0);
      run_op(8'h08, 8'h38, 8'h38, 2, 4'h0, 1'b0, 0);
      run_op(8'h0E, 8'h00, 8'h40, 1, 4'h0, 1'b1, 0);

      // flags byte
      run_op(8'h12, 8'h3C, 8'h40, 4, 4'b0001, 1'b0, 2);

      // timeout with WR_ACC set leaves acc alone; late done lands while output is stalled
      run_op(8'h08, 8'h11, 8'h22, 0, 4'h0, 1'b0, 0);
      run_op(8'h08, 8'h11, 8'h22, 18, 4'h5, 1'b0, 5);
      run_op(8'h06, 8'h00, 8'h40, 2, 4'h0, 1'b0, 0);

      // stray done while idle
      @(negedge clk);
      fpu_done_m = 1'b1;
      @(negedge clk);
      fpu_done_m = 1'b0;
      chk("stray_idle", {out_valid, busy, fpu_start}, 3'b000);

      // illegal commands
      run_op(8'hC0, 8'h00, 8'h00, 1, 4'h0, 1'b0, 0);
      run_op(8'h03, 8'h00, 8'h00, 1, 4'h0, 1'b0, 1);

      // output backpressure
      run_op(8'h02, 8'h3C, 8'h40, 3, 4'h0, 1'b0, 5);

      // ena low blocks command acceptance in IDLE
      @(negedge clk);
      ena = 1'b0;
      in_data = 8'h02;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("ena_gate", {in_ready, busy}, 2'b00);
      end
      in_valid = 1'b0;
      ena = 1'b1;

      for (int k = 0; k < 40; k++) begin
         c = 8'($urandom);
         c[7:6] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if ($urandom_range(0, 3) != 0) c[5] = 1'b0;
         lat = int'($urandom_range(1, 20));
         run_op(c, 8'($urandom), 8'($urandom), lat, 4'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
      end

      // reset in WAIT aborts the command and restores the accumulator
      run_op(8'h08, 8'h3C, 8'h40, 2, 4'h0, 1'b0, 0);
      stub_en = 1'b0;
      send_byte(8'h08, "rst_cmd");
      send_byte(8'h11, "rst_a");
      send_byte(8'h22, "rst_b");
      repeat (4) @(negedge clk);
      chk("rst_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_outputs", {in_ready, out_valid, out_data, fpu_start, fpu_op, fpu_a, fpu_b, busy, err}, '0);
      m_acc = 8'h00;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_output", {out_valid, busy}, 2'b00);
      end
      run_op(8'h06, 8'h00, 8'h40, 2, 4'h0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
